// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// txd is registered from the FSM state, so the line lags the state by one clk.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8,
   parameter int PTR_W        = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic             txd,
   output logic             busy,
   output logic [PTR_W:0]   fifo_count,
   output logic             tx_done
);
   localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [PTR_W:0]   DEPTH    = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             bit_end, wr_en, pop, txd_nxt;

   assign bit_end  = (baud_cnt == BIT_LAST);
   // Ready comes from the registered count, so a pop on the same edge
   // cannot open a slot for a write that is already being offered.
   assign wr_ready = (fifo_count < DEPTH);
   assign wr_en    = wr_valid & wr_ready;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fifo_count != '0) state_nxt = START;
         START:   if (bit_end) state_nxt = DATA;
         DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
         STOP:    if (bit_end) state_nxt = (fifo_count != '0) ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop     = 1'b0;
      txd_nxt = 1'b1;
      tx_done = 1'b0;
      case (state)
         IDLE:  pop = (fifo_count != '0);
         START: txd_nxt = 1'b0;
         DATA:  txd_nxt = shift[bit_idx];
         STOP: begin
            tx_done = bit_end;
            pop     = bit_end && (fifo_count != '0);
         end
         default: ;
      endcase
   end

   // Counter restarts on every state change so each bit is exactly CLKS_PER_BIT long.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         txd      <= 1'b1;
      end else begin
         txd <= txd_nxt;
         if (state_nxt != state || bit_end) baud_cnt <= '0;
         else if (state != IDLE)            baud_cnt <= baud_cnt + CNT_W'(1);
         if (state == START)                bit_idx <= '0;
         else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
         if (pop) shift <= mem[rd_ptr];
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: per-cycle vector tables for single frames, a line
// decoder feeding a byte scoreboard, and hand sequences for overflow/reset.
module tb_uart_tx_fifo;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int PW    = 2;
   localparam int CPB2  = 2;

   logic          clk = 1'b0;
   logic          resetn;
   logic [7:0]    wr_data, wr_data2;
   logic          wr_valid, wr_valid2;
   logic          wr_ready, txd, busy, tx_done;
   logic [PW:0]   fifo_count;
   logic          wr_ready2, txd2, busy2, tx_done2;
   logic [3:0]    fifo_count2;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic          mon_en  = 1'b0;
   logic [7:0]    sb [$];

   typedef struct {
      logic       wv;
      logic [7:0] wd;
      logic       e_txd;
      logic       e_busy;
      logic       e_done;
      logic [3:0] e_cnt;
   } vec_t;
   vec_t          vecs [64];
   int            n_vecs;

   int            busy_cnt, rises, dones, f1, f2, bad;
   logic          pb, pt;
   int            ovf_cnt [6] = '{1, 1, 2, 3, 4, 4};
   logic [7:0]    mon_b, mon_exp;
   logic          mon_st, mon_sp;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PTR_W(PW)) dut (
      .clk(clk), .resetn(resetn), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .txd(txd), .busy(busy), .fifo_count(fifo_count),
      .tx_done(tx_done)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(8), .PTR_W(3)) dut2 (
      .clk(clk), .resetn(resetn), .wr_data(wr_data2), .wr_valid(wr_valid2),
      .wr_ready(wr_ready2), .txd(txd2), .busy(busy2), .fifo_count(fifo_count2),
      .tx_done(tx_done2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Vector k drives edge k and checks the outputs just after it.
   function automatic void build_frame(input logic [7:0] b, input int cpb);
      n_vecs = 10*cpb + 5;
      for (int k = 0; k < n_vecs; k++) begin
         int bi;
         vecs[k].wv     = (k == 0);
         vecs[k].wd     = b;
         vecs[k].e_busy = (k >= 1 && k <= 10*cpb);
         vecs[k].e_done = (k == 10*cpb);
         vecs[k].e_cnt  = (k == 0) ? 4'd1 : 4'd0;
         vecs[k].e_txd  = 1'b1;
         if (k >= 2 && k < 2 + 10*cpb) begin
            bi = (k - 2) / cpb;
            if (bi == 0)      vecs[k].e_txd = 1'b0;
            else if (bi <= 8) vecs[k].e_txd = b[bi-1];
         end
      end
   endfunction

   task automatic run_vecs(input bit sel, input string tag);
      for (int k = 0; k < n_vecs; k++) begin
         if (!sel) begin
            wr_valid = vecs[k].wv;
            wr_data  = vecs[k].wd;
            if (vecs[k].wv) sb.push_back(vecs[k].wd);
         end else begin
            wr_valid2 = vecs[k].wv;
            wr_data2  = vecs[k].wd;
         end
         tick();
         if (!sel)
            check($sformatf("%s_v%0d", tag, k), {txd, busy, tx_done, 1'b0, fifo_count},
                  {vecs[k].e_txd, vecs[k].e_busy, vecs[k].e_done, vecs[k].e_cnt});
         else
            check($sformatf("%s_v%0d", tag, k), {txd2, busy2, tx_done2, fifo_count2},
                  {vecs[k].e_txd, vecs[k].e_busy, vecs[k].e_done, vecs[k].e_cnt});
      end
      wr_valid  = 1'b0;
      wr_valid2 = 1'b0;
   endtask

   // Line decoder: samples mid-bit and compares each frame with the scoreboard.
   always begin
      @(negedge clk);
      if (mon_en && resetn && txd === 1'b0) begin
         repeat (CPB/2) @(negedge clk);
         mon_st = ~txd;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_b[i] = txd;
         end
         repeat (CPB) @(negedge clk);
         mon_sp = txd;
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_unexpected_frame: got byte %0h expected no frame", mon_b);
         end else begin
            mon_exp = sb.pop_front();
            check("mon_frame", {mon_st, mon_sp, mon_b}, {1'b1, 1'b1, mon_exp});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_valid2 = 1'b0; wr_data2 = '0;
      repeat (3) tick();
      check("rst_state",  {txd, busy, tx_done, wr_ready, 1'b0, fifo_count}, 8'b1001_0000);
      check("rst_state2", {txd2, busy2, tx_done2, wr_ready2, fifo_count2}, 8'b1001_0000);
      resetn = 1'b1;
      tick();
      mon_en = 1'b1;

      build_frame(8'hA5, CPB);
      run_vecs(1'b0, "a5");
      check("a5_sb_empty", sb.size(), 0);

      busy_cnt = 0; rises = 0; dones = 0; f1 = -1; f2 = -1; pb = 1'b0; pt = 1'b1;
      for (int k = 0; k < 100; k++) begin
         wr_valid = (k < 2);
         wr_data  = (k == 0) ? 8'h00 : 8'hFF;
         if (k < 2) sb.push_back(wr_data);
         tick();
         if (busy) busy_cnt++;
         if (busy && !pb) rises++;
         if (tx_done) dones++;
         if (!txd && pt) begin
            if (f1 < 0) f1 = k;
            else if (f2 < 0) f2 = k;
         end
         pb = busy;
         pt = txd;
      end
      wr_valid = 1'b0;
      check("b2b_busy_cycles", busy_cnt, 80);
      check("b2b_busy_rises", rises, 1);
      check("b2b_done_pulses", dones, 2);
      check("b2b_first_fall", f1, 2);
      check("b2b_start_gap", f2 - f1, 40);
      check("b2b_sb_empty", sb.size(), 0);

      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'h10 + 8'(i);
         check($sformatf("ovf_ready_%0d", i), wr_ready, (i < 5));
         if (i < 5) sb.push_back(wr_data);
         tick();
         check($sformatf("ovf_count_%0d", i), fifo_count, ovf_cnt[i]);
      end
      wr_valid = 1'b0;
      repeat (35) tick();
      check("full_stop_end_done", tx_done, 1);
      check("full_stop_end_count", fifo_count, 4);
      wr_valid = 1'b1;
      wr_data  = 8'h20;
      check("full_pop_ready", wr_ready, 0);
      tick();
      check("full_pop_count", fifo_count, 3);
      wr_data = 8'h21;
      check("refill_ready", wr_ready, 1);
      sb.push_back(8'h21);
      tick();
      check("refill_count", fifo_count, 4);
      wr_valid = 1'b0;
      for (int i = 0; i < 800 && (busy || fifo_count != 0); i++) tick();
      check("ovf_drain", {busy, fifo_count}, 0);
      repeat (6) tick();
      check("ovf_sb_empty", sb.size(), 0);

      mon_en = 1'b0;
      wr_valid = 1'b1;
      wr_data = 8'h5A; tick();
      wr_data = 8'h01; tick();
      wr_data = 8'h02; tick();
      wr_valid = 1'b0;
      check("rst_q_count", fifo_count, 2);
      repeat (15) tick();
      check("rst_pre_bit2", txd, 0);
      tick();
      check("rst_pre_busy", busy, 1);
      resetn = 1'b0;
      tick();
      check("rst_mid_frame", {txd, busy, tx_done, 1'b0, fifo_count}, 7'b100_0000);
      resetn = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!txd || busy) bad++;
      end
      check("rst_no_residual", bad, 0);
      mon_en = 1'b1;

      build_frame(8'h81, CPB2);
      run_vecs(1'b1, "b81");

      check("sb_final_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
